wide_add_seq: RTL and testbench
===============================

WIDE_ADD_SEQ -- requirements
Module: wide_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, number of 16-bit beats per operation; legal range 1..8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1, requester presents an operation.
REQ-005 SHALL have port in_ready, output, 1, block can accept an operation.
REQ-006 SHALL have port op_a, input, 16*WORDS, first operand.
REQ-007 SHALL have port op_b, input, 16*WORDS, second operand.
REQ-008 SHALL have port sub, input, 1; 0 computes op_a+op_b, 1 computes op_a-op_b.
REQ-009 SHALL have port out_valid, output, 1, result available.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-011 SHALL have port result, output, 16*WORDS, sum or difference, modulo 2^(16*WORDS).
REQ-012 SHALL have port cout, output, 1, carry out of the MSB; for subtract, 1 = no borrow.
REQ-013 SHALL have port ovf, output, 1, two's-complement signed overflow.

Function
REQ-014 SHALL contain exactly one combinational 16-bit carry-skip adder slice: four 4-bit ripple groups, skip logic per group, with carry-in; it is used once per CALC cycle.
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-016 IDLE: on in_valid=1 at a clock edge, SHALL capture op_a, op_b xor {16*WORDS{sub}}, and sub; SHALL set carry register to sub and beat counter to 0; next state CALC.
REQ-017 CALC: each cycle, SHALL feed slice [16*beat+15:16*beat] of both captured operands plus the carry register into the adder; SHALL write the slice sum into the same slice of result; SHALL load the carry register with the slice carry out; SHALL increment beat.
REQ-018 CALC with beat=WORDS-1: SHALL register cout = slice carry out and ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the captured op_b after inversion; next state DONE.
REQ-019 Latency: when an operation is accepted at edge k, out_valid SHALL rise after edge k+WORDS.
REQ-020 DONE: result, cout and ovf SHALL stay stable while out_ready=0; on out_ready=1 at an edge, next state IDLE.
REQ-021 in_valid SHALL be ignored outside IDLE, and op_a/op_b/sub changes after capture SHALL NOT affect the result.
REQ-022 Maximum throughput SHALL be one operation per WORDS+2 cycles; no accept in the same cycle as a DONE handshake.
REQ-023 The beat counter SHALL be ceil(log2(WORDS)) bits, minimum 1 bit, and SHALL never exceed WORDS-1.
REQ-024 WORDS=1 SHALL spend exactly one cycle in CALC.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, beat 0, carry 0, result 0, cout 0, ovf 0, out_valid 0; in_ready reads 1 during and after reset.
REQ-026 Reset asserted in CALC or DONE SHALL abort the operation with no out_valid pulse; the first operation after release SHALL complete correctly.

Verification (WORDS=4)
REQ-027 add 0x0000_0000_0000_FFFF + 0x1 -> result 0x0000_0000_0001_0000, cout 0, ovf 0, out_valid rises 4 cycles after accept.
REQ-028 add 0xFFFF_FFFF_FFFF_FFFF + 0x1 (full ripple across all beats) -> result 0x0, cout 1, ovf 0.
REQ-029 sub 0x5 - 0x7 -> result 0xFFFF_FFFF_FFFF_FFFE, cout 0, ovf 0; sub 0x7 - 0x5 -> 0x2, cout 1.
REQ-030 add 0x7FFF_FFFF_FFFF_FFFF + 0x1 -> result 0x8000_0000_0000_0000, ovf 1, cout 0; sub 0x8000_0000_0000_0000 - 0x1 -> ovf 1.
REQ-031 backpressure: out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands -> out_valid held 1, result unchanged, in_ready 0, new operation accepted only after return to IDLE.
REQ-032 rst_n pulsed low during CALC beat 2 -> out_valid stays 0, in_ready 1 after release, next add 0x1234 + 0x1 gives 0x1235.

Source files
------------

// File: rtl/wide_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : wide_add_seq
//  Description : Multi-beat wide adder/subtractor. One 16-bit carry-skip slice
//                is reused once per beat, least-significant beat first.
//  Revision    : 1.0 - initial release
// ============================================================================
module wide_add_seq #(
    parameter int WORDS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [16*WORDS-1:0] op_a,
    input  logic [16*WORDS-1:0] op_b,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [16*WORDS-1:0] result,
    output logic                cout,
    output logic                ovf
);

    localparam int              DATA_W    = 16 * WORDS;
    localparam int              BEAT_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_result;
    logic [BEAT_W-1:0]   r_beat;
    logic                r_carry;
    logic                r_cout;
    logic                r_ovf;
    logic                r_in_ready;
    logic                r_out_valid;

    logic [15:0]         w_slice_a;
    logic [15:0]         w_slice_b;
    logic [15:0]         w_slice_sum;
    logic                w_slice_cout;
    logic [4:0]          w_grp_c;

    // Beat-indexed operand mux built from constant selects only.
    always_comb begin
        w_slice_a = 16'h0000;
        w_slice_b = 16'h0000;
        for (int i = 0; i < WORDS; i++) begin
            if (r_beat == BEAT_W'(i)) begin
                w_slice_a = r_a[16*i +: 16];
                w_slice_b = r_b[16*i +: 16];
            end
        end
    end

    // 16-bit carry-skip slice: four 4-bit ripple groups, each bypassed when
    // every bit of the group propagates.
    assign w_grp_c[0] = r_carry;

    for (genvar g = 0; g < 4; g++) begin : g_group
        logic [4:0] w_c;
        logic [3:0] w_p;

        assign w_c[0] = w_grp_c[g];

        for (genvar i = 0; i < 4; i++) begin : g_bit
            assign w_p[i]                = w_slice_a[4*g+i] ^ w_slice_b[4*g+i];
            assign w_slice_sum[4*g+i]    = w_p[i] ^ w_c[i];
            assign w_c[i+1]              = (w_slice_a[4*g+i] & w_slice_b[4*g+i])
                                         | (w_p[i] & w_c[i]);
        end

        assign w_grp_c[g+1] = (&w_p) ? w_grp_c[g] : w_c[4];
    end

    assign w_slice_cout = w_grp_c[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_beat      <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        // Subtraction is a + ~b + 1; the +1 rides in on the carry.
                        r_a        <= op_a;
                        r_b        <= op_b ^ {DATA_W{sub}};
                        r_carry    <= sub;
                        r_beat     <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_CALC;
                    end
                end

                ST_CALC: begin
                    for (int i = 0; i < WORDS; i++) begin
                        if (r_beat == BEAT_W'(i)) begin
                            r_result[16*i +: 16] <= w_slice_sum;
                        end
                    end
                    r_carry <= w_slice_cout;
                    if (r_beat == LAST_BEAT) begin
                        r_cout      <= w_slice_cout;
                        r_ovf       <= (w_slice_a[15] == w_slice_b[15]) &&
                                       (w_slice_sum[15] != w_slice_a[15]);
                        r_beat      <= '0;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end

                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_wide_add_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wide_add_seq
//  Description : Self-checking bench for wide_add_seq (WORDS=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wide_add_seq;

    localparam int WORDS  = 4;
    localparam int LAT    = WORDS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op_a;
    logic [63:0] op_b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        cout;
    logic        ovf;

    int n_vec = 0;
    int n_bad = 0;

    wide_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic [63:0] r;
        logic        c;
        logic        o;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: exact 65-bit unsigned and 66-bit signed arithmetic.
    task automatic model(input logic [63:0] a, input logic [63:0] b, input logic s,
                         output logic [63:0] r, output logic c, output logic o);
        logic [64:0]        full;
        logic signed [65:0] ea;
        logic signed [65:0] eb;
        logic signed [65:0] t;
        full = s ? ({1'b0, a} + {1'b0, ~b} + 65'd1) : ({1'b0, a} + {1'b0, b});
        r    = full[63:0];
        c    = full[64];
        ea   = {{2{a[63]}}, a};
        eb   = {{2{b[63]}}, b};
        t    = s ? (ea - eb) : (ea + eb);
        o    = !((t[65] == t[63]) && (t[64] == t[63]));
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic s,
                          output logic [63:0] r, output logic c, output logic o,
                          output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 20) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
        end
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        // Junk on the inputs during the operation must not disturb the result.
        op_a = {$urandom, $urandom};
        op_b = {$urandom, $urandom};
        sub  = 1'($urandom);
        wait_out(lat);
        in_valid = 1'b0;
        r = result; c = cout; o = ovf;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] r, er, held;
        logic        c, o, ec, eo;
        int          lat;

        tbl[0] = '{64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        tbl[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        tbl[2] = '{64'h5, 64'h7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        tbl[3] = '{64'h7, 64'h5, 1'b1, 64'h2, 1'b1, 1'b0};
        tbl[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        tbl[5] = '{64'h8000_0000_0000_0000, 64'h1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        tbl[6] = '{64'h0, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};
        tbl[7] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; sub = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result",    result,         64'd0);
        chk("rst_cout",      64'(cout),      64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].a, tbl[i].b, tbl[i].s, r, c, o, lat);
            chk($sformatf("tbl%0d_result", i), r, tbl[i].r);
            chk($sformatf("tbl%0d_cout", i), 64'(c), 64'(tbl[i].c));
            chk($sformatf("tbl%0d_ovf", i), 64'(o), 64'(tbl[i].o));
            chk($sformatf("tbl%0d_latency", i), 64'(lat), 64'(LAT));
        end

        // Backpressure: DONE held while a new request waits on in_valid.
        op_a = 64'h1111; op_b = 64'h2222; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        op_a = 64'h10; op_b = 64'h20; sub = 1'b0;
        wait_out(lat);
        chk("bp_latency", 64'(lat), 64'(LAT));
        held = result;
        chk("bp_result", held, 64'h3333);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid_held", 64'(out_valid), 64'd1);
            chk("bp_result_stable",  result,         64'h3333);
            chk("bp_in_ready_low",   64'(in_ready),  64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_idle_in_ready",  64'(in_ready),  64'd1);
        chk("bp_idle_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_accept_in_ready", 64'(in_ready), 64'd0);
        wait_out(lat);
        chk("bp2_latency", 64'(lat), 64'(LAT));
        chk("bp2_result",  result,   64'h30);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // Reset asserted while beat 2 is in flight.
        op_a = 64'hAAAA; op_b = 64'h1; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  64'(in_ready),  64'd1);
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_result",    result,         64'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("mid_rst_no_valid", 64'(out_valid), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_in_ready",  64'(in_ready),  64'd1);
        chk("rel_out_valid", 64'(out_valid), 64'd0);
        run_op(64'h1234, 64'h1, 1'b0, r, c, o, lat);
        chk("rel_result",  r,         64'h1235);
        chk("rel_latency", 64'(lat),  64'(LAT));

        // Randomized operations against the reference model.
        for (int n = 0; n < 60; n++) begin
            logic [63:0] a, b;
            logic        s;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s = 1'($urandom);
            case ($urandom_range(0, 3))
                0: ;
                1: b = ~a;
                2: begin a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'($urandom_range(0, 3)); end
                default: b = a;
            endcase
            model(a, b, s, er, ec, eo);
            run_op(a, b, s, r, c, o, lat);
            chk($sformatf("rnd%0d_result", n), r, er);
            chk($sformatf("rnd%0d_cout", n), 64'(c), 64'(ec));
            chk($sformatf("rnd%0d_ovf", n), 64'(o), 64'(eo));
            chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'(LAT));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
